tour_cmd: RTL
=============

# tour_cmd

Command sequencer that reads a solved knight's tour out of the tour solver and replays it as movement commands to the command processor. It drives the solver's 5-bit move index, decodes each one-hot 8-bit move into a vertical leg and a horizontal leg, and handshakes each leg with the command processor. When not replaying a tour, it transparently forwards UART commands.

## Interface
Parameters:
- none (board 5x5, 24 moves, fixed)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse; solver done, begin replay at index 0
- move  in  8  one-hot move addressed by mv_indx (solver read port, combinational)
- mv_indx  out  5  index of move being replayed, 0..23
- cmd_UART  in  16  command from UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- cmd  out  16  command to command processor: [15:12] opcode, [11:4] heading, [3:0] squares
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor accepted cmd
- send_resp  in  1  command processor finished executing cmd
- resp  out  8  response byte to UART: 8'hA5 = done/ack, 8'h5A = tour leg ack

## Operation
- Move decode (x+ = east, y+ = north), lowest set bit wins, 8'h00 -> 0 squares:
  - bit0 N2 E1; bit1 N2 W1; bit2 N1 W2; bit3 S1 W2; bit4 S2 W1; bit5 S2 E1; bit6 S1 E2; bit7 N1 E2.
- Headings: N 8'h00, W 8'h3F, S 8'h7F, E 8'hBF.
- Vertical leg: opcode 4'b0010 (move), heading N/S, squares 1 or 2.
- Horizontal leg: opcode 4'b0011 (move with fanfare), heading E/W, squares 1 or 2.
- States: IDLE, VERT, HOLD_V, HORZ, HOLD_H.
  - IDLE: cmd = cmd_UART, cmd_rdy = cmd_rdy_UART. start_tour -> clear mv_indx, go VERT.
  - VERT: cmd = vertical leg, cmd_rdy = 1. clr_cmd_rdy -> HOLD_V.
  - HOLD_V: cmd_rdy = 0, cmd holds vertical leg. send_resp -> HORZ.
  - HORZ: cmd = horizontal leg, cmd_rdy = 1. clr_cmd_rdy -> HOLD_H.
  - HOLD_H: cmd_rdy = 0. send_resp: if mv_indx == 23 -> IDLE, else increment mv_indx, go VERT.
- resp: 8'hA5 in IDLE or when mv_indx == 23; otherwise 8'h5A. Evaluated combinationally.
- start_tour outside IDLE is ignored.
- cmd_rdy_UART outside IDLE is ignored and not forwarded.
- clr_cmd_rdy in HOLD_V/HOLD_H is ignored. send_resp in VERT/HORZ is ignored, so a leg cannot complete before it is accepted.
- mv_indx stays at 23 when returning to IDLE. It is cleared only by start_tour or reset.

## Timing
- Reset: state IDLE, mv_indx 5'd0. cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, resp = 8'hA5.
- cmd, cmd_rdy and resp are combinational from state, mv_indx, move and the UART inputs. No added latency.
- mv_indx is registered. move is valid in the same cycle as mv_indx, because the solver read is combinational.
- start_tour at edge N: cmd_rdy = 1 with the vertical leg of move 0 during cycle N+1.
- clr_cmd_rdy at edge N: cmd_rdy = 0 from N+1.
- send_resp in HOLD_H at edge N: the next move's vertical leg is presented with cmd_rdy = 1 in N+1.
- Minimum per move: 4 cycles, each handshake taking one cycle.
- Reset asserted mid-tour: state is IDLE and mv_indx is 0 immediately (asynchronous), and cmd_rdy drops to the cmd_rdy_UART value.

## Test plan
- Reset, then cmd_UART = 16'h1234, cmd_rdy_UART = 1 -> cmd = 16'h1234, cmd_rdy = 1, resp = 8'hA5, mv_indx = 0.
- start_tour with move[0] = 8'h01 -> cmd 16'h2002 with cmd_rdy = 1; after clr_cmd_rdy then send_resp -> cmd 16'h3BF1 with cmd_rdy = 1; resp = 8'h5A.
- Decode sweep using moves 8'h04, 8'h40, 8'h10 -> vertical/horizontal pairs 16'h2001/16'h33F2, 16'h27F1/16'h3BF2, 16'h27F2/16'h33F1.
- Full 24-move tour with random handshake delays of 0-20 cycles -> exactly 48 commands, mv_indx steps 0..23, final resp 8'hA5, then back to IDLE and UART passthrough.
- Illegal-order events: send_resp asserted in VERT, start_tour asserted mid-tour, cmd_rdy_UART asserted in HORZ -> no state or index change; UART command not forwarded.
- rst_n asserted low in HOLD_V at mv_indx = 7 -> immediate IDLE and mv_indx = 0; a following start_tour restarts from index 0.

Source files
------------

// File: rtl/tour_cmd.sv
// Knight's-tour command sequencer: replays solver moves as vertical/horizontal
// move commands with a cmd_rdy/clr_cmd_rdy/send_resp handshake; forwards UART commands when idle.
module tour_cmd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned LAST_IDX = 23;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] VERT   = 3'd1;
  localparam logic [2:0] HOLD_V = 3'd2;
  localparam logic [2:0] HORZ   = 3'd3;
  localparam logic [2:0] HOLD_H = 3'd4;

  localparam logic [3:0] OP_MOVE    = 4'b0010;
  localparam logic [3:0] OP_FANFARE = 4'b0011;
  localparam logic [7:0] HEAD_N     = 8'h00;
  localparam logic [7:0] HEAD_W     = 8'h3F;
  localparam logic [7:0] HEAD_S     = 8'h7F;
  localparam logic [7:0] HEAD_E     = 8'hBF;
  localparam logic [7:0] RESP_DONE  = 8'hA5;
  localparam logic [7:0] RESP_LEG   = 8'h5A;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             v_south, h_west;
  logic [1:0]       v_sq, h_sq;
  logic [15:0]      vert_leg, horz_leg;
  logic             last_move;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Split one-hot move into legs; lowest set bit has priority, no bit means 0 squares.
  always_comb begin
    v_south = 1'b0;
    h_west  = 1'b0;
    v_sq    = 2'd0;
    h_sq    = 2'd0;
    casez (move)
      8'b???????1: begin v_sq = 2'd2; h_sq = 2'd1; end
      8'b??????10: begin v_sq = 2'd2; h_sq = 2'd1; h_west = 1'b1; end
      8'b?????100: begin v_sq = 2'd1; h_sq = 2'd2; h_west = 1'b1; end
      8'b????1000: begin v_sq = 2'd1; h_sq = 2'd2; h_west = 1'b1; v_south = 1'b1; end
      8'b???10000: begin v_sq = 2'd2; h_sq = 2'd1; h_west = 1'b1; v_south = 1'b1; end
      8'b??100000: begin v_sq = 2'd2; h_sq = 2'd1; v_south = 1'b1; end
      8'b?1000000: begin v_sq = 2'd1; h_sq = 2'd2; v_south = 1'b1; end
      8'b10000000: begin v_sq = 2'd1; h_sq = 2'd2; end
      default: ;
    endcase
  end

  assign vert_leg  = {OP_MOVE, (v_south ? HEAD_S : HEAD_N), 2'b00, v_sq};
  assign horz_leg  = {OP_FANFARE, (h_west ? HEAD_W : HEAD_E), 2'b00, h_sq};
  assign last_move = (idx_q == IDX_W'(LAST_IDX));

  // Sequencer: next state, index update and command mux.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    case (state_q)
      IDLE: begin
        if (start_tour) begin
          idx_d   = '0;
          state_d = VERT;
        end
      end
      VERT: begin
        cmd     = vert_leg;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_V;
      end
      HOLD_V: begin
        cmd     = vert_leg;
        cmd_rdy = 1'b0;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_leg;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = HOLD_H;
      end
      HOLD_H: begin
        cmd     = horz_leg;
        cmd_rdy = 1'b0;
        if (send_resp) begin
          if (last_move) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign resp    = ((state_q == IDLE) || last_move) ? RESP_DONE : RESP_LEG;
  assign mv_indx = idx_q;

endmodule
